// File: rtl/furv_lsu.sv
// -----------------------------------------------------------------------------
// furv_lsu -- load/store unit driving a Wishbone-style bus.
//
// Takes one load/store request at a time from the core. It generates the byte
// selects and lane-shifted write data, steers the read lanes back to bit 0 and
// sign- or zero-extends the load result.
//
// Optional build macro: FURV_LSU_MISALIGNED_EN
//   defined   : accesses crossing a beat boundary are split into two beats.
//   undefined : any access with addr mod size != 0 completes with resp_err = 1
//               and no bus cycle.
//
// Parameters
//   DATA_WIDTH  32 or 64; bus and register width (B = DATA_WIDTH/8 bytes)
//   ADDR_WIDTH  byte-address width
//   TIMEOUT     cycles to wait for bus_ack per beat; 0 waits forever
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   req_valid      request strobe; accepted while req_ready = 1
//   req_ready      high only when idle
//   req_write      1 = store, 0 = load
//   req_width      0 byte, 1 half, 2 word, 3 dword (dword needs DATA_WIDTH=64)
//   req_unsigned   load zero-extends instead of sign-extending
//   req_addr       byte address
//   req_wdata      right-aligned store data
//   resp_valid     one-cycle completion pulse
//   resp_rdata     extended load data; 0 for stores and errors
//   resp_err       error flag qualified by resp_valid
//   bus_cyc/stb    bus cycle / strobe
//   bus_we         bus write enable
//   bus_addr       beat (word) address
//   bus_sel        byte-lane enables
//   bus_dat_o      lane-shifted write data
//   bus_dat_i      read data
//   bus_ack        beat acknowledge, only honoured while bus_stb = 1
// -----------------------------------------------------------------------------
module furv_lsu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          req_valid,
  output logic                                          req_ready,
  input  logic                                          req_write,
  input  logic [1:0]                                    req_width,
  input  logic                                          req_unsigned,
  input  logic [ADDR_WIDTH-1:0]                         req_addr,
  input  logic [DATA_WIDTH-1:0]                         req_wdata,
  output logic                                          resp_valid,
  output logic [DATA_WIDTH-1:0]                         resp_rdata,
  output logic                                          resp_err,
  output logic                                          bus_cyc,
  output logic                                          bus_stb,
  output logic                                          bus_we,
  output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]    bus_addr,
  output logic [DATA_WIDTH/8-1:0]                       bus_sel,
  output logic [DATA_WIDTH-1:0]                         bus_dat_o,
  input  logic [DATA_WIDTH-1:0]                         bus_dat_i,
  input  logic                                          bus_ack
);

  localparam int unsigned B    = DATA_WIDTH / 8;
  localparam int unsigned OFFW = $clog2(B);
  localparam int unsigned BAW  = ADDR_WIDTH - OFFW;
  localparam int unsigned NW   = OFFW + 1;
  localparam int unsigned TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT0,
    S_BEAT1,
    S_RESP
  } state_t;

  state_t                 state;
  logic [OFFW-1:0]        r_off;
  logic [1:0]             r_width;
  logic                   r_unsigned;
  logic                   r_write;
  logic [TW-1:0]          tcnt;

  // Request decode, evaluated on the incoming request while idle.
  int unsigned            off_i;
  int unsigned            n_i;
  logic [OFFW-1:0]        req_off;
  logic                   req_bad_width;
  logic                   req_reject;
  logic [B-1:0]           req_sel0;
  logic [DATA_WIDTH-1:0]  req_dat0;

  // Load return path.
  logic [DATA_WIDTH-1:0]  rd_asm;
  logic [DATA_WIDTH-1:0]  rd_ext;
  logic                   rd_fill;
  int unsigned            rd_n;
  logic                   timeout_hit;

`ifdef FURV_LSU_MISALIGNED_EN
  logic                   r_span;
  logic [B-1:0]           r_sel1;
  logic [DATA_WIDTH-1:0]  r_dat1;
  logic [DATA_WIDTH-1:0]  r_rbuf;
  logic                   req_span;
  logic [B-1:0]           req_sel1;
  logic [NW-1:0]          req_bsub;
  logic [DATA_WIDTH-1:0]  req_dat1;
  logic [NW-1:0]          rd_bsub;
`else
  logic                   req_misaligned;
`endif

  always_comb begin
    req_off       = req_addr[OFFW-1:0];
    off_i         = 32'(req_off);
    n_i           = 32'd1 << req_width;
    req_bad_width = n_i > B;
    req_dat0      = req_wdata << {req_off, 3'b000};
    for (int unsigned i = 0; i < B; i++) begin
      req_sel0[i] = (i >= off_i) && (i < off_i + n_i);
    end
`ifdef FURV_LSU_MISALIGNED_EN
    req_span = (off_i + n_i) > B;
    // Upper part of the lane window that spills into the next beat.
    for (int unsigned i = 0; i < B; i++) begin
      req_sel1[i] = (i + B) < (off_i + n_i);
    end
    req_bsub   = NW'(B) - {1'b0, req_off};
    req_dat1   = req_wdata >> {req_bsub, 3'b000};
    req_reject = req_bad_width;
`else
    req_misaligned = (off_i & (n_i - 32'd1)) != 32'd0;
    req_reject     = req_bad_width || req_misaligned;
`endif
  end

  always_comb begin
    // First beat: lanes off..B-1 land in result bytes 0..B-off-1.
    rd_asm = bus_dat_i >> {r_off, 3'b000};
`ifdef FURV_LSU_MISALIGNED_EN
    rd_bsub = NW'(B) - {1'b0, r_off};
    if (state == S_BEAT1) begin
      rd_asm = r_rbuf | (bus_dat_i << {rd_bsub, 3'b000});
    end
`endif
    rd_n = 32'd1 << r_width;
    case (r_width)
      2'd0:    rd_fill = rd_asm[7];
      2'd1:    rd_fill = rd_asm[15];
      default: rd_fill = rd_asm[31];
    endcase
    rd_fill = rd_fill & ~r_unsigned;
    for (int unsigned i = 0; i < B; i++) begin
      rd_ext[8*i +: 8] = (i < rd_n) ? rd_asm[8*i +: 8] : {8{rd_fill}};
    end
    timeout_hit = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      bus_cyc    <= 1'b0;
      bus_stb    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_sel    <= '0;
      bus_dat_o  <= '0;
      r_off      <= '0;
      r_width    <= '0;
      r_unsigned <= 1'b0;
      r_write    <= 1'b0;
      tcnt       <= '0;
`ifdef FURV_LSU_MISALIGNED_EN
      r_span     <= 1'b0;
      r_sel1     <= '0;
      r_dat1     <= '0;
      r_rbuf     <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            r_off      <= req_off;
            r_width    <= req_width;
            r_unsigned <= req_unsigned;
            r_write    <= req_write;
            req_ready  <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            tcnt       <= '0;
`ifdef FURV_LSU_MISALIGNED_EN
            r_span     <= req_span;
            r_sel1     <= req_sel1;
            r_dat1     <= req_dat1;
            r_rbuf     <= '0;
`endif
            if (req_reject) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state     <= S_BEAT0;
              bus_cyc   <= 1'b1;
              bus_stb   <= 1'b1;
              bus_we    <= req_write;
              bus_addr  <= req_addr[ADDR_WIDTH-1:OFFW];
              bus_sel   <= req_sel0;
              bus_dat_o <= req_dat0;
            end
          end
        end

        S_BEAT0, S_BEAT1: begin
          if (bus_ack) begin
            tcnt <= '0;
`ifdef FURV_LSU_MISALIGNED_EN
            // cyc/stb stay high straight into the second beat.
            if (state == S_BEAT0 && r_span) begin
              state     <= S_BEAT1;
              bus_addr  <= bus_addr + BAW'(1);
              bus_sel   <= r_sel1;
              bus_dat_o <= r_dat1;
              r_rbuf    <= rd_asm;
            end else
`endif
            begin
              state      <= S_RESP;
              bus_cyc    <= 1'b0;
              bus_stb    <= 1'b0;
              bus_we     <= 1'b0;
              bus_addr   <= '0;
              bus_sel    <= '0;
              bus_dat_o  <= '0;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= r_write ? '0 : rd_ext;
            end
          end else if (timeout_hit) begin
            state      <= S_RESP;
            bus_cyc    <= 1'b0;
            bus_stb    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_sel    <= '0;
            bus_dat_o  <= '0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end

        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_furv_lsu.sv
module tb_furv_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  // 32-bit instance (TIMEOUT = 4)
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_width;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        bus_cyc, bus_stb, bus_we, bus_ack;
  logic [29:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_dat_o, bus_dat_i;

  // 64-bit instance (no timeout)
  logic        req_valid_w, req_ready_w, req_write_w, req_unsigned_w;
  logic [1:0]  req_width_w;
  logic [31:0] req_addr_w;
  logic [63:0] req_wdata_w;
  logic        resp_valid_w, resp_err_w;
  logic [63:0] resp_rdata_w;
  logic        bus_cyc_w, bus_stb_w, bus_we_w, bus_ack_w;
  logic [28:0] bus_addr_w;
  logic [7:0]  bus_sel_w;
  logic [63:0] bus_dat_o_w, bus_dat_i_w;

  furv_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_width(req_width), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_dat_o(bus_dat_o),
    .bus_dat_i(bus_dat_i), .bus_ack(bus_ack)
  );

  furv_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT(0)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_w), .req_ready(req_ready_w), .req_write(req_write_w),
    .req_width(req_width_w), .req_unsigned(req_unsigned_w), .req_addr(req_addr_w),
    .req_wdata(req_wdata_w), .resp_valid(resp_valid_w), .resp_rdata(resp_rdata_w),
    .resp_err(resp_err_w), .bus_cyc(bus_cyc_w), .bus_stb(bus_stb_w), .bus_we(bus_we_w),
    .bus_addr(bus_addr_w), .bus_sel(bus_sel_w), .bus_dat_o(bus_dat_o_w),
    .bus_dat_i(bus_dat_i_w), .bus_ack(bus_ack_w)
  );

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    logic [28:0] addr;
    logic [7:0]  sel;
    logic [63:0] rdata;
    logic        err;
  } txn64_t;

  beat_t       beat_q[$];
  resp_t       resp_q[$];
  logic [31:0] rd_q[$];
  txn64_t      txn64_q[$];

  int nvec = 0;
  int nerr = 0;
  int resp_cnt = 0;
  int resp_cnt_w = 0;
  int cyc_cnt = 0;
  int resp_cycle = 0;
  int last_accept = 0;
  bit ack_en = 1'b1;
  bit ack_force = 1'b0;
  int ack_delay = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_beat(input logic [29:0] a, input logic [3:0] s, input logic we, input logic [31:0] d);
    beat_t b;
    b.addr = a; b.sel = s; b.we = we; b.dat = d;
    beat_q.push_back(b);
  endtask

  task automatic exp_resp(input logic [31:0] d, input logic e);
    resp_t r;
    r.rdata = d; r.err = e;
    resp_q.push_back(r);
  endtask

  task automatic exp64(input logic [28:0] a, input logic [7:0] s, input logic [63:0] d, input logic e);
    txn64_t t;
    t.addr = a; t.sel = s; t.rdata = d; t.err = e;
    txn64_q.push_back(t);
  endtask

  // Bus slave for the 32-bit instance: acks after ack_delay stb cycles.
  initial begin
    int waited;
    waited = 0;
    bus_ack = 1'b0;
    bus_dat_i = '0;
    forever begin
      @(negedge clk);
      if (ack_force) begin
        bus_ack = 1'b1;
      end else if (bus_stb && ack_en) begin
        if (waited >= ack_delay) begin
          bus_ack = 1'b1;
          bus_dat_i = '0;
          if (rd_q.size() > 0) bus_dat_i = rd_q.pop_front();
          waited = 0;
        end else begin
          bus_ack = 1'b0;
          waited++;
        end
      end else begin
        bus_ack = 1'b0;
        waited = 0;
      end
    end
  end

  // Bus slave for the 64-bit instance: immediate ack, fixed data.
  initial begin
    bus_ack_w = 1'b0;
    bus_dat_i_w = 64'h8877_6655_4433_2211;
    forever begin
      @(negedge clk);
      bus_ack_w = bus_stb_w;
    end
  end

  // Bus monitor: every stb cycle must match the head expected beat.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk); #1;
      if (bus_cyc || bus_stb) begin
        if (beat_q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_bus_cycle: cyc=%b stb=%b addr=0x%0h, expected idle bus",
                   bus_cyc, bus_stb, bus_addr);
        end else begin
          e = beat_q[0];
          chk("bus_cyc", bus_cyc, 1);
          chk("bus_stb", bus_stb, 1);
          chk("bus_addr", bus_addr, e.addr);
          chk("bus_sel", bus_sel, e.sel);
          chk("bus_we", bus_we, e.we);
          if (e.we) chk("bus_dat_o", bus_dat_o, e.dat);
          if (bus_ack) void'(beat_q.pop_front());
        end
      end
    end
  end

  // Response monitor.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk); #1;
      if (resp_valid) begin
        resp_cnt++;
        resp_cycle = cyc_cnt;
        if (resp_q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_resp: rdata=0x%0h err=%b, expected no response", resp_rdata, resp_err);
        end else begin
          e = resp_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", resp_err, e.err);
        end
      end
    end
  end

  // Monitor for the 64-bit instance.
  initial begin
    txn64_t t;
    forever begin
      @(negedge clk); #1;
      if (bus_stb_w) begin
        if (txn64_q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_bus64: addr=0x%0h, expected idle bus", bus_addr_w);
        end else begin
          chk("bus64_addr", bus_addr_w, txn64_q[0].addr);
          chk("bus64_sel", bus_sel_w, txn64_q[0].sel);
        end
      end
      if (resp_valid_w) begin
        resp_cnt_w++;
        if (txn64_q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_resp64: rdata=0x%0h, expected no response", resp_rdata_w);
        end else begin
          t = txn64_q.pop_front();
          chk("resp64_rdata", resp_rdata_w, t.rdata);
          chk("resp64_err", resp_err_w, t.err);
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [1:0] w, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input bit wait_resp);
    int start;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_width = w; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    start = resp_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    last_accept = cyc_cnt;
    chk("req_ready_busy", req_ready, 0);
    if (wait_resp) begin
      for (int i = 0; i < 30; i++) begin
        if (resp_cnt != start) break;
        @(negedge clk); #2;
      end
      if (resp_cnt == start) begin
        nvec++; nerr++;
        $display("FAIL resp_timeout: no resp_valid within 30 cycles, expected one");
      end
    end
  endtask

  task automatic issue64(input logic [1:0] w, input logic uns, input logic [31:0] a);
    int start;
    @(negedge clk);
    req_valid_w = 1'b1; req_write_w = 1'b0; req_width_w = w; req_unsigned_w = uns;
    req_addr_w = a; req_wdata_w = '0;
    start = resp_cnt_w;
    @(posedge clk); #1;
    req_valid_w = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (resp_cnt_w != start) break;
      @(negedge clk); #2;
    end
    if (resp_cnt_w == start) begin
      nvec++; nerr++;
      $display("FAIL resp64_timeout: no resp_valid within 30 cycles, expected one");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int start;
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_width = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    req_valid_w = 0; req_write_w = 0; req_width_w = 0; req_unsigned_w = 0; req_addr_w = 0; req_wdata_w = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_bus_cyc", bus_cyc, 0);
    chk("rst_bus_stb", bus_stb, 0);
    chk("rst_bus_sel", bus_sel, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    rst = 1'b0;

    // Signed byte load at 0x103, then unsigned.
    exp_beat(30'h40, 4'b1000, 1'b0, 32'h0); rd_q.push_back(32'h80FF_FF00);
    exp_resp(32'hFFFF_FF80, 1'b0);
    issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1'b1);
    chk("latency_edges", 64'(resp_cycle - last_accept), 1);

    exp_beat(30'h40, 4'b1000, 1'b0, 32'h0); rd_q.push_back(32'h80FF_FF00);
    exp_resp(32'h0000_0080, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1'b1);

    // Store half 0xBEEF at 0x202.
    exp_beat(30'h80, 4'b1100, 1'b1, 32'hBEEF_0000);
    exp_resp(32'h0, 1'b0);
    issue(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234_BEEF, 1'b1);

    // Signed half load, word load, store byte with upper junk.
    exp_beat(30'h4, 4'b0011, 1'b0, 32'h0); rd_q.push_back(32'h1234_8001);
    exp_resp(32'hFFFF_8001, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 1'b1);

    exp_beat(30'h8, 4'b1111, 1'b0, 32'h0); rd_q.push_back(32'hDEAD_BEEF);
    exp_resp(32'hDEAD_BEEF, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1);

    exp_beat(30'hC, 4'b0010, 1'b1, 32'hFFFF_A500);
    exp_resp(32'h0, 1'b0);
    issue(1'b1, 2'd0, 1'b0, 32'h31, 32'hFFFF_FFA5, 1'b1);

    // Ack arrives on the third stb cycle.
    ack_delay = 2;
    exp_beat(30'h10, 4'b1111, 1'b0, 32'h0); rd_q.push_back(32'h0BAD_F00D);
    exp_resp(32'h0BAD_F00D, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b1);
    ack_delay = 0;

    // Ack while idle must be ignored.
    start = resp_cnt;
    @(negedge clk); ack_force = 1'b1;
    repeat (3) @(negedge clk);
    ack_force = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("idle_ack_no_resp", 64'(resp_cnt - start), 0);

    // Dword on a 32-bit build: error, no bus cycle.
    exp_resp(32'h0, 1'b1);
    issue(1'b0, 2'd3, 1'b0, 32'h8, 32'h0, 1'b1);

`ifdef FURV_LSU_MISALIGNED_EN
    exp_beat(30'h1, 4'b1100, 1'b0, 32'h0); rd_q.push_back(32'hAABB_CCDD);
    exp_beat(30'h2, 4'b0011, 1'b0, 32'h0); rd_q.push_back(32'h1122_3344);
    exp_resp(32'h3344_AABB, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 1'b1);

    exp_beat(30'h3FFF_FFFF, 4'b1100, 1'b1, 32'hF00D_0000);
    exp_beat(30'h0, 4'b0011, 1'b1, 32'h0000_CAFE);
    exp_resp(32'h0, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'hCAFE_F00D, 1'b1);

    exp_beat(30'h0, 4'b1000, 1'b0, 32'h0); rd_q.push_back(32'h7F00_0000);
    exp_beat(30'h1, 4'b0001, 1'b0, 32'h0); rd_q.push_back(32'h0000_0080);
    exp_resp(32'hFFFF_807F, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 32'h3, 32'h0, 1'b1);

    exp_beat(30'h0, 4'b0110, 1'b0, 32'h0); rd_q.push_back(32'h00AB_CD00);
    exp_resp(32'h0000_ABCD, 1'b0);
    issue(1'b0, 2'd1, 1'b1, 32'h1, 32'h0, 1'b1);
`else
    exp_resp(32'h0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 1'b1);
    exp_resp(32'h0, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'hCAFE_F00D, 1'b1);
    exp_resp(32'h0, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 32'h3, 32'h0, 1'b1);
    exp_resp(32'h0, 1'b1);
    issue(1'b0, 2'd1, 1'b1, 32'h1, 32'h0, 1'b1);
`endif

    // Timeout: no ack, stb high for exactly 4 cycles, then error.
    ack_en = 1'b0;
    exp_beat(30'h14, 4'b1111, 1'b0, 32'h0);
    exp_resp(32'h0, 1'b1);
    start = resp_cnt;
    issue(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, 1'b0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #2;
      if (bus_stb) n++;
      if (resp_cnt != start) break;
    end
    chk("timeout_stb_cycles", 64'(n), 4);
    chk("timeout_resp_seen", 64'(resp_cnt - start), 1);
    chk("timeout_beat_left", 64'(beat_q.size()), 1);
    beat_q.delete();

    // Reset during BEAT0: cyc drops next edge, no response.
    exp_beat(30'h18, 4'b1111, 1'b0, 32'h0);
    start = resp_cnt;
    issue(1'b0, 2'd2, 1'b0, 32'h60, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #2;
    chk("rst_mid_cyc", bus_cyc, 0);
    chk("rst_mid_stb", bus_stb, 0);
    chk("rst_mid_ready", req_ready, 1);
    rst = 1'b0;
    ack_en = 1'b1;
    chk("rst_mid_beat_left", 64'(beat_q.size()), 1);
    beat_q.delete();
    repeat (4) @(negedge clk);
    #2;
    chk("rst_mid_no_resp", 64'(resp_cnt - start), 0);

    // Normal traffic resumes after the reset.
    exp_beat(30'h20, 4'b0100, 1'b0, 32'h0); rd_q.push_back(32'h00F0_0000);
    exp_resp(32'hFFFF_FFF0, 1'b0);
    issue(1'b0, 2'd0, 1'b0, 32'h82, 32'h0, 1'b1);

    // 64-bit instance.
    exp64(29'h1, 8'hFF, 64'h8877_6655_4433_2211, 1'b0);
    issue64(2'd3, 1'b0, 32'h8);
    exp64(29'h1, 8'h80, 64'hFFFF_FFFF_FFFF_FF88, 1'b0);
    issue64(2'd0, 1'b0, 32'hF);
    exp64(29'h1, 8'hF0, 64'h0000_0000_8877_6655, 1'b0);
    issue64(2'd2, 1'b1, 32'hC);
    exp64(29'h1, 8'hF0, 64'hFFFF_FFFF_8877_6655, 1'b0);
    issue64(2'd2, 1'b0, 32'hC);

    repeat (4) @(negedge clk);
    chk("beat_q_drained", 64'(beat_q.size()), 0);
    chk("resp_q_drained", 64'(resp_q.size()), 0);
    chk("txn64_q_drained", 64'(txn64_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
